// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  dmem_arb_pkg : shared types for the two-port data-memory arbiter
//  Rev 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int PORT_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic        be;
        logic [31:0] a;
        logic [31:0] wd;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
//  dmem_arb_pick : fixed-priority pick with port-1 anti-starvation counter
//  Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              decide,
    output logic              sel_valid,
    output logic [PORT_W-1:0] sel_port
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          w_pick1;

    assign w_pick1   = req1 & (~req0 | (wait_cnt_q == WAIT_MAX));
    assign sel_valid = decide & (req0 | req1);
    assign sel_port  = PORT_W'(w_pick1);

    // Only contested port-0 wins count as a port-1 loss.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (sel_valid) begin
            if (w_pick1) begin
                wait_cnt_d = '0;
            end else if (req1 && (wait_cnt_q != WAIT_MAX)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  dmem_arbiter : shares a single-port byte-capable data memory between
//                 the load/store path (port 0) and a secondary master (port 1)
//  Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WORDS = 64,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic        be0,
    input  logic [31:0] a0,
    input  logic [31:0] wd0,
    output logic        gnt0,
    output logic        done0,
    output logic [31:0] rd0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic        be1,
    input  logic [31:0] a1,
    input  logic [31:0] wd1,
    output logic        gnt1,
    output logic        done1,
    output logic [31:0] rd1,
    output logic        err1,
    output logic        mem_we,
    output logic        mem_be,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [29:0] WORD_LIMIT = 30'(ADDR_WORDS);

    arb_state_t        state_q;
    logic [PORT_W-1:0] owner_q;
    mem_req_t          req_q;
    logic              in_range_q;
    logic [31:0]       rdata_q;

    logic              w_decide, w_sel_valid, w_in_range;
    logic [PORT_W-1:0] w_sel_port;
    mem_req_t          w_new;
    logic              w_issue, w_resp, w_own0, w_own1;

    assign w_decide   = (state_q == IDLE) || (state_q == RESP);
    assign w_new      = (w_sel_port == PORT_W'(1)) ? '{we: we1, be: be1, a: a1, wd: wd1}
                                                   : '{we: we0, be: be0, a: a0, wd: wd0};
    assign w_in_range = (w_new.a[31:2] < WORD_LIMIT);

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .decide    (w_decide),
        .sel_valid (w_sel_valid),
        .sel_port  (w_sel_port)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            req_q      <= '0;
            in_range_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (w_sel_valid) begin
                        owner_q    <= w_sel_port;
                        req_q      <= w_new;
                        in_range_q <= w_in_range;
                        state_q    <= ISSUE;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                ISSUE: begin
                    // Memory has already sampled the read on the preceding negedge.
                    rdata_q <= (in_range_q && !req_q.we) ? mem_rd : '0;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_issue = (state_q == ISSUE);
    assign w_resp  = (state_q == RESP);
    assign w_own0  = (owner_q == PORT_W'(0));
    assign w_own1  = (owner_q == PORT_W'(1));

    assign mem_we  = w_issue & req_q.we & in_range_q;
    assign mem_be  = w_issue & req_q.be;
    assign mem_a   = w_issue ? req_q.a  : '0;
    assign mem_wd  = w_issue ? req_q.wd : '0;

    assign gnt0    = w_issue & w_own0;
    assign gnt1    = w_issue & w_own1;
    assign done0   = w_resp & w_own0;
    assign done1   = w_resp & w_own1;
    assign rd0     = done0 ? rdata_q : '0;
    assign rd1     = done1 ? rdata_q : '0;
    assign err0    = done0 & ~in_range_q;
    assign err1    = done1 & ~in_range_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  tb_dmem_arbiter : vector table + scoreboard bench with a behavioural RAM
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0 = 0, we0 = 0, be0 = 0, req1 = 0, we1 = 0, be1 = 0;
    logic [31:0] a0 = 0, wd0 = 0, a1 = 0, wd1 = 0;
    logic        gnt0, done0, err0, gnt1, done1, err1;
    logic [31:0] rd0, rd1;
    logic        mem_we, mem_be;
    logic [31:0] mem_a, mem_wd;
    logic [31:0] mem_rd = '0;

    dmem_arbiter #(.ADDR_WORDS(64), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .be0(be0), .a0(a0), .wd0(wd0),
        .gnt0(gnt0), .done0(done0), .rd0(rd0), .err0(err0),
        .req1(req1), .we1(we1), .be1(be1), .a1(a1), .wd1(wd1),
        .gnt1(gnt1), .done1(done1), .rd1(rd1), .err1(err1),
        .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM: read on negedge, write on posedge.
    logic [31:0] ram    [0:63];
    logic [31:0] shadow [0:63];

    always @(negedge clk) begin
        if (mem_a[31:2] < 30'd64) begin
            if (mem_be) mem_rd <= {24'd0, ram[mem_a[7:2]][8*mem_a[1:0] +: 8]};
            else        mem_rd <= ram[mem_a[7:2]];
        end else begin
            mem_rd <= '0;
        end
    end

    always @(posedge clk) begin
        if (mem_we && mem_a[31:2] < 30'd64) begin
            if (mem_be) ram[mem_a[7:2]][8*mem_a[1:0] +: 8] <= mem_wd[7:0];
            else        ram[mem_a[7:2]] <= mem_wd;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          port;
        logic [31:0] rd;
        bit          err;
    } sb_t;
    sb_t sb[$];

    // Scoreboard consumer plus idle-bus checks.
    always @(negedge clk) begin
        if (!reset) begin
            if (done0 || done1) begin
                chk("single_done", {62'd0, done0, done1}, {62'd0, !done1, done1});
                if (sb.size() == 0) begin
                    chk("unexpected_done", {62'd0, done0, done1}, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("done_port", {63'd0, done1}, {63'd0, e.port});
                    if (e.port) begin
                        chk("rd1", {32'd0, rd1}, {32'd0, e.rd});
                        chk("err1", {63'd0, err1}, {63'd0, e.err});
                        chk("idle_p0", {31'd0, err0, rd0}, 64'd0);
                    end else begin
                        chk("rd0", {32'd0, rd0}, {32'd0, e.rd});
                        chk("err0", {63'd0, err0}, {63'd0, e.err});
                        chk("idle_p1", {31'd0, err1, rd1}, 64'd0);
                    end
                end
            end
            if (!gnt0 && !gnt1)
                chk("mem_idle", {mem_we, mem_be, 30'd0, mem_a | mem_wd}, 64'd0);
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        bit          be;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    function automatic logic gnt_of(bit p);
        return p ? gnt1 : gnt0;
    endfunction

    function automatic logic done_of(bit p);
        return p ? done1 : done0;
    endfunction

    task automatic drive(bit p, bit we, bit be, logic [31:0] a, logic [31:0] wd);
        if (p) begin req1 = 1; we1 = we; be1 = be; a1 = a; wd1 = wd; end
        else   begin req0 = 1; we0 = we; be0 = be; a0 = a; wd0 = wd; end
    endtask

    task automatic drop(bit p);
        if (p) req1 = 0; else req0 = 0;
    endtask

    task automatic shadow_write(bit be, logic [31:0] a, logic [31:0] wd);
        if (a[31:2] < 30'd64) begin
            if (be) shadow[a[7:2]][8*a[1:0] +: 8] = wd[7:0];
            else    shadow[a[7:2]] = wd;
        end
    endtask

    // Called at a negedge; returns at the negedge where done should be high.
    task automatic apply(vec_t v);
        sb.push_back('{port: v.port, rd: v.rd, err: v.err});
        drive(v.port, v.we, v.be, v.a, v.wd);
        @(negedge clk);
        chk("gnt",    {63'd0, gnt_of(v.port)}, 64'd1);
        chk("mem_a",  {32'd0, mem_a}, {32'd0, v.a});
        chk("mem_we", {63'd0, mem_we}, {63'd0, v.we & ~v.err});
        chk("mem_be", {63'd0, mem_be}, {63'd0, v.be});
        chk("mem_wd", {32'd0, mem_wd}, {32'd0, v.wd});
        drop(v.port);
        @(negedge clk);
        chk("done", {63'd0, done_of(v.port)}, 64'd1);
        if (v.we) shadow_write(v.be, v.a, v.wd);
    endtask

    vec_t vecs[11];
    int   k;
    int   prev_g;
    bit   got;
    bit   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]    = 32'hC0DE_0000 | i;
            shadow[i] = 32'hC0DE_0000 | i;
        end
        ram[2]    = 32'hDEAD_BEEF;
        shadow[2] = 32'hDEAD_BEEF;

        vecs[0]  = '{0, 0, 0, 32'h08,  32'h0,         32'hDEAD_BEEF, 0};
        vecs[1]  = '{1, 1, 1, 32'h05,  32'h0000_00A5, 32'h0,         0};
        vecs[2]  = '{1, 0, 1, 32'h05,  32'h0,         32'h0000_00A5, 0};
        vecs[3]  = '{1, 0, 0, 32'h04,  32'h0,         32'hC0DE_A501, 0};
        vecs[4]  = '{0, 1, 0, 32'h0C,  32'hCAFE_F00D, 32'h0,         0};
        vecs[5]  = '{0, 0, 0, 32'h0C,  32'h0,         32'hCAFE_F00D, 0};
        vecs[6]  = '{1, 0, 1, 32'h0F,  32'h0,         32'h0000_00CA, 0};
        vecs[7]  = '{0, 1, 0, 32'h100, 32'h5555_AAAA, 32'h0,         1};
        vecs[8]  = '{1, 0, 0, 32'hFC,  32'h0,         32'hC0DE_003F, 0};
        vecs[9]  = '{1, 0, 0, 32'h100, 32'h0,         32'h0,         1};
        vecs[10] = '{0, 0, 1, 32'h0B,  32'h0,         32'h0000_00DE, 0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", {gnt0, gnt1, done0, done1, err0, err1, mem_we, mem_be, 24'd0, rd0 | rd1 | mem_a | mem_wd}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) apply(vecs[i]);
        chk("ram1_byte", {32'd0, ram[1]}, {32'd0, 32'hC0DE_A501});

        // Back-to-back reads on port 0, address advanced at each grant
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            sb.push_back('{port: 0, rd: shadow[i], err: 0});
        drive(0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_gnt", {63'd0, gnt0}, 64'd1);
            if (i < 2) a0 = 32'(4 * (i + 1));
            else       drop(0);
            @(negedge clk);
            chk("b2b_done", {63'd0, done0}, 64'd1);
        end

        // Reset during the issue cycle of a port-0 write
        @(negedge clk);
        drive(0, 1, 0, 32'h10, 32'h1234_5678);
        @(negedge clk);
        chk("rst_gnt", {63'd0, gnt0}, 64'd1);
        chk("rst_we_pre", {63'd0, mem_we}, 64'd1);
        #2 reset = 1'b1;
        #1 chk("rst_we_async", {62'd0, mem_we, gnt0}, 64'd0);
        @(negedge clk);
        drop(0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_done", {62'd0, done0, gnt0}, 64'd0);
        end
        chk("rst_ram4", {32'd0, ram[4]}, {32'd0, shadow[4]});

        // Contention: both ports hold read requests continuously
        for (int i = 0; i < 10; i++)
            sb.push_back('{port: exp_order[i], rd: exp_order[i] ? shadow[1] : shadow[0], err: 0});
        drive(0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 32'h4, 32'h0);
        prev_g = 0;
        for (int i = 0; i < 10; i++) begin
            got = 0;
            for (int t = 0; t < 4 && !got; t++) begin
                @(negedge clk);
                if (gnt0 || gnt1) got = 1;
            end
            chk("cont_gnt_seen", {63'd0, got}, 64'd1);
            if (!got) break;
            chk("cont_order", {62'd0, gnt1, gnt0}, exp_order[i] ? 64'd2 : 64'd1);
            if (i > 0) chk("cont_spacing", 64'(cyc - prev_g), 64'd2);
            prev_g = cyc;
            if (i == 9) begin drop(0); drop(1); end
        end
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        sb.delete();

        // Readback of every word
        for (int i = 0; i < 64; i++) begin
            vec_t v;
            v = '{0, 0, 0, 32'(4 * i), 32'h0, shadow[i], 0};
            apply(v);
        end
        @(negedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
